// File: rtl/peripheral_bus_pkg.sv
// Shared constants for the memory-mapped peripheral block: register offsets
// within the peripheral window, TCON bit layout and 7-segment constants.
package peripheral_bus_pkg;

    // Byte offsets of each register inside the 32-byte peripheral window
    localparam logic [4:0] PERIPH_TH      = 5'h00;
    localparam logic [4:0] PERIPH_TL      = 5'h04;
    localparam logic [4:0] PERIPH_TCON    = 5'h08;
    localparam logic [4:0] PERIPH_LED     = 5'h0C;
    localparam logic [4:0] PERIPH_SWITCH  = 5'h10;
    localparam logic [4:0] PERIPH_DIGI    = 5'h14;
    localparam logic [4:0] PERIPH_SYSTICK = 5'h18;

    // TCON bit positions
    localparam int TCON_TMR_EN  = 0;
    localparam int TCON_IRQ_EN  = 1;
    localparam int TCON_IRQ_STS = 2;

    // Timer control register, packed so it maps directly onto TCON[2:0]
    typedef struct packed {
        logic irq_sts;
        logic irq_en;
        logic tmr_en;
    } tcon_t;

    // Active-low segment patterns, bit order gfedcba
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    // Word-aligned offset of a byte address inside the window
    function automatic logic [4:0] word_offset(input logic [31:0] a);
        return {a[4:2], 2'b00};
    endfunction

endpackage

// File: rtl/peripheral_bus_seg7_decoder.sv
// Hex nibble to active-low 7-segment pattern (bit order gfedcba).
module seg7_decoder
    import peripheral_bus_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Pure lookup of the glyph for each hex digit
    always_comb begin
        seg = SEG_BLANK;
        case (hex)
            4'h0: seg = SEG_ZERO;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/peripheral_bus.sv
// Memory-mapped peripherals behind the MIPS core's data-memory port:
// reloading timer with interrupt, LED and 7-segment registers, switch input
// and a free-running system tick counter.
// Optional build macro SWITCH_SYNC_EN adds a 2-FF synchronizer plus a
// debounce filter on the switch inputs; without it SWITCH reads the raw pins.
module peripheral_bus
    import peripheral_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0000,
    parameter logic [15:0] DEBOUNCE_CYC = 16'd50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [7:0]  switch,
    output logic [7:0]  led,
    output logic [6:0]  digi1,
    output logic [6:0]  digi2,
    output logic [6:0]  digi3,
    output logic [6:0]  digi4,
    output logic        irq_out
);

    logic [31:0] th;
    logic [31:0] tl;
    tcon_t       tcon;
    logic [7:0]  led_reg;
    logic [15:0] digi_reg;
    logic [31:0] systick;
    logic [7:0]  switch_val;

    logic        hit;
    logic [4:0]  offset;
    logic        wr_hit;
    logic        overflow;

    assign hit      = (addr[31:5] == BASE_ADDR[31:5]);
    assign offset   = word_offset(addr);
    assign wr_hit   = mem_wr && hit;
    assign overflow = tcon.tmr_en && (tl == 32'hFFFF_FFFF);

    // Timer registers: CPU writes to TL beat counting, and an enabled
    // overflow sets irq_sts even when software clears it in the same cycle.
    // Reload reads th before any same-cycle write lands, so it uses old TH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th   <= '0;
            tl   <= '0;
            tcon <= '0;
        end else begin
            if (wr_hit && offset == PERIPH_TH) begin
                th <= wdata;
            end
            if (wr_hit && offset == PERIPH_TL) begin
                tl <= wdata;
            end else if (tcon.tmr_en) begin
                tl <= overflow ? th : tl + 32'd1;
            end
            if (wr_hit && offset == PERIPH_TCON) begin
                tcon <= tcon_t'(wdata[2:0]);
            end
            if (overflow && tcon.irq_en) begin
                tcon.irq_sts <= 1'b1;
            end
        end
    end

    // Free-running tick counter, wraps naturally at 2^32
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            systick <= '0;
        end else begin
            systick <= systick + 32'd1;
        end
    end

    // Board output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_reg  <= '0;
            digi_reg <= '0;
        end else begin
            if (wr_hit && offset == PERIPH_LED) begin
                led_reg <= wdata[7:0];
            end
            if (wr_hit && offset == PERIPH_DIGI) begin
                digi_reg <= wdata[15:0];
            end
        end
    end

`ifdef SWITCH_SYNC_EN
    logic [7:0]  sync1;
    logic [7:0]  sync2;
    logic [7:0]  candidate;
    logic [7:0]  switch_reg;
    logic [15:0] stable_cnt;
    logic        unused_ok;

    assign unused_ok  = &{1'b0, addr[1:0]};
    assign switch_val = switch_reg;

    // Synchronize the pins, then accept a new value only once it has held
    // steady for DEBOUNCE_CYC cycles; any change restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1      <= '0;
            sync2      <= '0;
            candidate  <= '0;
            switch_reg <= '0;
            stable_cnt <= '0;
        end else begin
            sync1 <= switch;
            sync2 <= sync1;
            if (sync2 != candidate) begin
                candidate  <= sync2;
                stable_cnt <= '0;
            end else if (candidate != switch_reg) begin
                if (stable_cnt >= DEBOUNCE_CYC - 16'd1) begin
                    switch_reg <= candidate;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 16'd1;
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end
`else
    logic unused_ok;

    assign unused_ok  = &{1'b0, addr[1:0], DEBOUNCE_CYC};
    assign switch_val = switch;
`endif

    // Combinational load data; zero unless a load hits the window
    always_comb begin
        rdata = '0;
        if (mem_rd && hit) begin
            case (offset)
                PERIPH_TH:      rdata = th;
                PERIPH_TL:      rdata = tl;
                PERIPH_TCON:    rdata = {29'd0, tcon};
                PERIPH_LED:     rdata = {24'd0, led_reg};
                PERIPH_SWITCH:  rdata = {24'd0, switch_val};
                PERIPH_DIGI:    rdata = {16'd0, digi_reg};
                PERIPH_SYSTICK: rdata = systick;
                default:        rdata = '0;
            endcase
        end
    end

    assign led     = led_reg;
    assign irq_out = tcon.irq_sts & tcon.irq_en;

    seg7_decoder u_dec1 (.hex(digi_reg[3:0]),   .seg(digi1));
    seg7_decoder u_dec2 (.hex(digi_reg[7:4]),   .seg(digi2));
    seg7_decoder u_dec3 (.hex(digi_reg[11:8]),  .seg(digi3));
    seg7_decoder u_dec4 (.hex(digi_reg[15:12]), .seg(digi4));

endmodule

// File: tb/tb_peripheral_bus.sv
// Self-checking bench for peripheral_bus: expected values are pushed to a
// scoreboard queue as stimulus is applied and popped when the DUT output is
// sampled (half a cycle away from the rising edge).
`timescale 1ns/1ps
module tb_peripheral_bus;

    localparam logic [31:0] A_TH      = 32'h4000_0000;
    localparam logic [31:0] A_TL      = 32'h4000_0004;
    localparam logic [31:0] A_TCON    = 32'h4000_0008;
    localparam logic [31:0] A_LED     = 32'h4000_000C;
    localparam logic [31:0] A_SWITCH  = 32'h4000_0010;
    localparam logic [31:0] A_DIGI    = 32'h4000_0014;
    localparam logic [31:0] A_SYSTICK = 32'h4000_0018;
    localparam logic [31:0] A_RSVD    = 32'h4000_001C;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clk;
    logic        reset;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  switch;
    logic [7:0]  led;
    logic [6:0]  digi1, digi2, digi3, digi4;
    logic        irq_out;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    peripheral_bus dut (
        .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .addr(addr), .wdata(wdata), .rdata(rdata), .switch(switch),
        .led(led), .digi1(digi1), .digi2(digi2), .digi3(digi3),
        .digi4(digi4), .irq_out(irq_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input string name, input logic [31:0] val);
        exp_t x;
        x.name = name;
        x.val  = val;
        sb.push_back(x);
    endtask

    // Store lands on the rising edge in the middle of this task
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        mem_rd = 1'b0;
        mem_wr = 1'b1;
        addr   = a;
        wdata  = d;
        @(negedge clk);
        mem_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a);
        mem_rd = 1'b1;
        addr   = a;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0;
        addr = '0; wdata = '0; switch = 8'h4A;
        repeat (3) @(negedge clk);
        #1;
        push("led_in_reset", 32'h0);
        e = sb.pop_front(); checks++;
        if ({24'd0, led} !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, led, e.val); end
        push("irq_in_reset", 32'h0);
        e = sb.pop_front(); checks++;
        if ({31'd0, irq_out} !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, irq_out, e.val); end
        @(negedge clk);
        reset = 1'b0;
        push("systick_at_release", 32'h0);
        bus_read(A_SYSTICK);
        e = sb.pop_front(); checks++;
        if (rdata !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, rdata, e.val); end
        push("rdata_no_rd", 32'h0);
        mem_rd = 1'b0; addr = A_SWITCH; #1;
        e = sb.pop_front(); checks++;
        if (rdata !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, rdata, e.val); end
        push("digi1_reset", {25'd0, 7'b1000000});
        push("digi2_reset", {25'd0, 7'b1000000});
        push("digi3_reset", {25'd0, 7'b1000000});
        push("digi4_reset", {25'd0, 7'b1000000});
        e = sb.pop_front(); checks++;
        if ({25'd0, digi1} !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, digi1, e.val); end
        e = sb.pop_front(); checks++;
        if ({25'd0, digi2} !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, digi2, e.val); end
        e = sb.pop_front(); checks++;
        if ({25'd0, digi3} !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, digi3, e.val); end
        e = sb.pop_front(); checks++;
        if ({25'd0, digi4} !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, digi4, e.val); end
        tick(); tick();
        push("systick_after_2", 32'd2);
        push("tl_reset", 32'h0);
        push("tcon_reset", 32'h0);
        bus_read(A_SYSTICK);
        e = sb.pop_front(); checks++;
        if (rdata !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, rdata, e.val); end
        bus_read(A_TL);
        e = sb.pop_front(); checks++;
        if (rdata !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, rdata, e.val); end
        bus_read(A_TCON);
        e = sb.pop_front(); checks++;
        if (rdata !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, rdata, e.val); end
`ifdef SWITCH_SYNC_EN
        begin
            int n;
            n = 0;
            bus_read(A_SWITCH);
            while (rdata !== 32'h4A && n < 50100) begin
                @(negedge clk); #1; n++;
            end
        end
`endif
        push("switch_read", 32'h0000_004A);
        bus_read(A_SWITCH);
        e = sb.pop_front(); checks++;
        if (rdata !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, rdata, e.val); end
    endtask

    task automatic test_timer();
        logic [31:0] tl_exp [4]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        logic        irq_exp [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        tick();
        bus_write(A_TH, 32'hFFFF_FFFD);
        bus_write(A_TL, 32'hFFFF_FFFD);
        bus_write(A_TCON, 32'h3);
        for (int i = 0; i < 4; i++) begin
            push($sformatf("tl_count%0d", i), tl_exp[i]);
            push($sformatf("irq_count%0d", i), {31'd0, irq_exp[i]});
        end
        for (int i = 0; i < 4; i++) begin
            bus_read(A_TL);
            e = sb.pop_front(); checks++;
            if (rdata !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, rdata, e.val); end
            e = sb.pop_front(); checks++;
            if ({31'd0, irq_out} !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, irq_out, e.val); end
            if (i < 3) tick();
        end
        push("tcon_after_reload", 32'h7);
        bus_read(A_TCON);
        e = sb.pop_front(); checks++;
        if (rdata !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, rdata, e.val); end
    endtask

    task automatic test_irq_clear();
        bus_write(A_TCON, 32'h1);
        push("irq_after_clear", 32'h0);
        push("tl_keeps_counting", 32'hFFFF_FFFE);
        push("tcon_after_clear", 32'h1);
        e = sb.pop_front(); checks++;
        if ({31'd0, irq_out} !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, irq_out, e.val); end
        bus_read(A_TL);
        e = sb.pop_front(); checks++;
        if (rdata !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, rdata, e.val); end
        bus_read(A_TCON);
        e = sb.pop_front(); checks++;
        if (rdata !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, rdata, e.val); end
        // Re-enable the interrupt, let it fire, then clear irq_sts (irq_en kept)
        // on the very cycle of the next overflow.
        bus_write(A_TCON, 32'h3);
        tick();
        push("irq_refire", 32'h1);
        e = sb.pop_front(); checks++;
        if ({31'd0, irq_out} !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, irq_out, e.val); end
        tick(); tick();
        push("tl_before_overlap", 32'hFFFF_FFFF);
        bus_read(A_TL);
        e = sb.pop_front(); checks++;
        if (rdata !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, rdata, e.val); end
        bus_write(A_TCON, 32'h3);
        push("irq_hw_set_wins", 32'h1);
        push("tcon_hw_set_wins", 32'h7);
        push("tl_overlap_reload", 32'hFFFF_FFFD);
        e = sb.pop_front(); checks++;
        if ({31'd0, irq_out} !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, irq_out, e.val); end
        bus_read(A_TCON);
        e = sb.pop_front(); checks++;
        if (rdata !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, rdata, e.val); end
        bus_read(A_TL);
        e = sb.pop_front(); checks++;
        if (rdata !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, rdata, e.val); end
    endtask

    task automatic test_back_to_back();
        tick(); tick();
        bus_write(A_TH, 32'h1234_0000);
        push("reload_uses_old_th", 32'hFFFF_FFFD);
        push("th_written", 32'h1234_0000);
        bus_read(A_TL);
        e = sb.pop_front(); checks++;
        if (rdata !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, rdata, e.val); end
        bus_read(A_TH);
        e = sb.pop_front(); checks++;
        if (rdata !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, rdata, e.val); end
        tick(); tick();
        bus_write(A_TL, 32'h0000_0010);
        push("tl_write_wins", 32'h0000_0010);
        push("tl_count_after_write", 32'h0000_0011);
        bus_read(A_TL);
        e = sb.pop_front(); checks++;
        if (rdata !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, rdata, e.val); end
        tick();
        bus_read(A_TL);
        e = sb.pop_front(); checks++;
        if (rdata !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, rdata, e.val); end
        bus_write(A_TCON, 32'h0);
        tick();
        push("tl_holds_disabled", 32'h0000_0012);
        push("irq_disabled", 32'h0);
        bus_read(A_TL);
        e = sb.pop_front(); checks++;
        if (rdata !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, rdata, e.val); end
        e = sb.pop_front(); checks++;
        if ({31'd0, irq_out} !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, irq_out, e.val); end
    endtask

    task automatic test_digi();
        logic [3:0] k4;
        tick();
        bus_write(A_DIGI, 32'h0000_12AF);
        push("digi1_F", {25'd0, 7'b0001110});
        push("digi2_A", {25'd0, 7'b0001000});
        push("digi3_2", {25'd0, 7'b0100100});
        push("digi4_1", {25'd0, 7'b1111001});
        push("digi_read", 32'h0000_12AF);
        e = sb.pop_front(); checks++;
        if ({25'd0, digi1} !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, digi1, e.val); end
        e = sb.pop_front(); checks++;
        if ({25'd0, digi2} !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, digi2, e.val); end
        e = sb.pop_front(); checks++;
        if ({25'd0, digi3} !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, digi3, e.val); end
        e = sb.pop_front(); checks++;
        if ({25'd0, digi4} !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, digi4, e.val); end
        bus_read(A_DIGI);
        e = sb.pop_front(); checks++;
        if (rdata !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, rdata, e.val); end
        for (int k = 0; k < 16; k++) begin
            k4 = k[3:0];
            bus_write(A_DIGI, {16'hFFFF, {4{k4}}});
            push($sformatf("digi1_%0h", k), {25'd0, SEG_TABLE[k]});
            push($sformatf("digi4_%0h", k), {25'd0, SEG_TABLE[k]});
            e = sb.pop_front(); checks++;
            if ({25'd0, digi1} !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, digi1, e.val); end
            e = sb.pop_front(); checks++;
            if ({25'd0, digi4} !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, digi4, e.val); end
        end
    endtask

    task automatic test_led_window();
        tick();
        bus_write(A_LED, 32'hFFFF_FF5A);
        push("led_port", 32'h0000_005A);
        push("led_read", 32'h0000_005A);
        push("led_read_unaligned", 32'h0000_005A);
        e = sb.pop_front(); checks++;
        if ({24'd0, led} !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, led, e.val); end
        bus_read(A_LED);
        e = sb.pop_front(); checks++;
        if (rdata !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, rdata, e.val); end
        bus_read(32'h4000_000D);
        e = sb.pop_front(); checks++;
        if (rdata !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, rdata, e.val); end
        tick();
        bus_write(32'h4000_0020, 32'h0);
        bus_write(32'h1000_000C, 32'h0);
        bus_write(A_RSVD, 32'hFFFF_FFFF);
        bus_write(A_SWITCH, 32'h0);
        push("led_outside_write", 32'h0000_005A);
        push("th_outside_write", 32'h1234_0000);
        push("rsvd_reads_zero", 32'h0);
        push("above_window_zero", 32'h0);
        push("other_region_zero", 32'h0);
        push("switch_ro", 32'h0000_004A);
        e = sb.pop_front(); checks++;
        if ({24'd0, led} !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, led, e.val); end
        bus_read(A_TH);
        e = sb.pop_front(); checks++;
        if (rdata !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, rdata, e.val); end
        bus_read(A_RSVD);
        e = sb.pop_front(); checks++;
        if (rdata !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, rdata, e.val); end
        tick();
        bus_read(32'h4000_0020);
        e = sb.pop_front(); checks++;
        if (rdata !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, rdata, e.val); end
        bus_read(32'h1000_000C);
        e = sb.pop_front(); checks++;
        if (rdata !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, rdata, e.val); end
        bus_read(A_SWITCH);
        e = sb.pop_front(); checks++;
        if (rdata !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, rdata, e.val); end
    endtask

    task automatic test_async_reset();
        tick();
        bus_write(A_TH, 32'h0);
        bus_write(A_TL, 32'hFFFF_FFFE);
        bus_write(A_TCON, 32'h3);
        tick(); tick();
        push("irq_before_reset", 32'h1);
        e = sb.pop_front(); checks++;
        if ({31'd0, irq_out} !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, irq_out, e.val); end
        @(posedge clk);
        #1 reset = 1'b1;
        push("tl_async_reset", 32'h0);
        push("tcon_async_reset", 32'h0);
        push("systick_async_reset", 32'h0);
        push("irq_async_reset", 32'h0);
        bus_read(A_TL);
        e = sb.pop_front(); checks++;
        if (rdata !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, rdata, e.val); end
        bus_read(A_TCON);
        e = sb.pop_front(); checks++;
        if (rdata !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, rdata, e.val); end
        bus_read(A_SYSTICK);
        e = sb.pop_front(); checks++;
        if (rdata !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, rdata, e.val); end
        e = sb.pop_front(); checks++;
        if ({31'd0, irq_out} !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, irq_out, e.val); end
        tick();
        reset = 1'b0;
        tick(); tick();
        push("tl_idle_after_reset", 32'h0);
        bus_read(A_TL);
        e = sb.pop_front(); checks++;
        if (rdata !== e.val) begin errors++; $display("[TB] FAIL %s got=%h exp=%h", e.name, rdata, e.val); end
    endtask

    initial begin
        test_reset();
        test_timer();
        test_irq_clear();
        test_back_to_back();
        test_digi();
        test_led_window();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
